gf_serial_mulred: RTL and testbench
===================================

Name: gf_serial_mulred

Overview:
- Iterative multi-cycle arithmetic engine consuming the operand/mode bundle the PCPI Galois wrapper registers: `op_enable`, `in_a`/`in_b`, `in_width`, `polyn_red_in`, `red_funct`, `carry_option`.
- Computes an integer or carry-less 2W-bit product, and optionally reduces it modulo a GF(2^m) primitive polynomial.
- Returns results with a single-cycle `op_finish` pulse.
- Trades latency for area: one multiplier bit per cycle, one reduction bit per cycle.

Parameters:
- DATA_WIDTH, 32, operand width W; must be even and ≥4.

Ports:
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous active-low reset
- op_enable  in  1  start request; sampled only when busy=0
- red_funct  in  1  1 = reduce product mod polyn_red_in (forces carry-less)
- carry_option  in  1  1 = integer multiply, 0 = carry-less; ignored when red_funct=1
- in_width  in  $clog2(W)+1  field degree m
- polyn_red_in  in  W+1  primitive polynomial, bit m set
- in_a  in  W  operand A
- in_b  in  W  operand B
- out_mult  out  2W  full product (unreduced)
- out_poly  out  W  reduced result (red_funct=1), else out_mult[W-1:0]
- op_finish  out  1  one-cycle result-valid pulse
- busy  out  1  engine in MUL or RED

Behaviour:
- Reset (async, resetn=0): state=IDLE, counters=0; out_mult, out_poly, op_finish, busy all 0. Reset mid-operation aborts it; no op_finish is produced.
- States:
  - IDLE
  - MUL
  - RED
  - DONE
- Start (edge 0): in IDLE or DONE with op_enable=1:
  - latch in_a, in_b, mode, polynomial and m;
  - clear the accumulator;
  - go to MUL.
- Degree m: m=0 or m>W is treated as m=W.
- Operand masking: when red_funct=1, operands are masked to m bits.
- MUL (edges 1..W):
  - if b[i]=1, accumulator ^= (a<<i) when carry-less, or += (a<<i) when integer; 2W-bit arithmetic, no overflow possible;
  - on the last MUL edge: go to RED if red_funct=1 and m≥2, else go to DONE.
- RED (m-1 edges), bit positions j = 2m-2 down to m:
  - if acc[j]=1, acc ^= polyn_red_in<<(j-m);
  - on the last RED edge, go to DONE.
  - out_mult keeps the unreduced product, captured at MUL exit.
- Result update: out_mult and out_poly update on the same edge that asserts op_finish.
- DONE: op_finish=1 for exactly one cycle, busy=0.
  - Next edge: IDLE, or MUL if op_enable=1 (back-to-back start).
- Latency (edge 0 = sampling edge): op_finish is high after edge L, where:
  - L = W with no reduction, or when m=1;
  - L = W+m-1 with reduction.
- Busy handling: op_enable while busy=1 is ignored and not queued. Input changes while busy are ignored (operands are latched).
- Outputs between operations: out_mult and out_poly hold their values until the next op_finish.

Optional Feature:
- Macro: GF_RADIX4_EN.
- Defined: MUL consumes 2 bits of b per edge (partial products a<<i and a<<(i+1) combined in one step); MUL takes W/2 edges, so L = W/2 or W/2+m-1. RED is unchanged.
- Undefined: radix-2 datapath as above.
- Results are bit-identical in both builds.

Decomposition:
- Shared package gf_pkg:
  - state enum {IDLE, MUL, RED, DONE};
  - localparams for W, log2 width, MUL_STEPS (W or W/2).
- Sub-module gf_red_step: one combinational conditional-XOR reduction step (acc, polynomial, j, m → acc'). Keeps the RED datapath separately testable.

Test Plan:
- AES field: m=8, polyn=0x11B, a=0x57, b=0x83, red_funct=1 → out_mult=0x2B79, out_poly=0xC1; op_finish after edge 39 (radix-2, W=32).
- Integer: carry_option=1, red_funct=0, a=b=0xFFFFFFFF → out_mult=0xFFFFFFFE00000001, out_poly=0x00000001; op_finish after edge 32.
- Carry-less: carry_option=0, a=b=0x80000000 → out_mult=0x4000000000000000.
- Full-width field: m=32, polyn=0x1_0000008D, a=0x80000000, b=0x2, red_funct=1 → out_poly=0x0000008D.
- Busy/back-to-back: pulse op_enable again at edge 5 with different operands → ignored, first result unchanged. op_enable held during the op_finish cycle → new operation starts immediately, busy high next cycle.
- Reset mid-op: drop resetn at edge 10 → all outputs 0 immediately, no op_finish. A new op after release completes with correct values.

Source files
------------

// File: rtl/gf_pkg.sv
// Shared types and constants for the serial GF multiply/reduce engine.
// Optional build macro: GF_RADIX4_EN (two multiplier bits per MUL edge).
package gf_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      RED  = 2'd2,
      DONE = 2'd3
   } state_e;

   localparam int W      = 32;
   localparam int LOG2_W = $clog2(W);

`ifdef GF_RADIX4_EN
   localparam int RADIX_BITS = 2;
`else
   localparam int RADIX_BITS = 1;
`endif

   localparam int MUL_STEPS = W / RADIX_BITS;

endpackage

// File: rtl/gf_red_step.sv
// One conditional-XOR reduction step: if acc[j] is set, cancel it by
// XOR-ing in the field polynomial aligned so its degree-m bit lands on j.
module gf_red_step #(
   parameter int DATA_WIDTH = 32,
   parameter int MW         = $clog2(DATA_WIDTH) + 1
) (
   input  logic [2*DATA_WIDTH-1:0] acc_i,
   input  logic [DATA_WIDTH:0]     poly_i,
   input  logic [MW-1:0]           j_i,
   input  logic [MW-1:0]           m_i,
   output logic [2*DATA_WIDTH-1:0] acc_o
);

   logic [MW-1:0]           shamt;
   logic [2*DATA_WIDTH-1:0] poly_ext;

   assign shamt    = j_i - m_i;
   assign poly_ext = {{(DATA_WIDTH-1){1'b0}}, poly_i} << shamt;
   assign acc_o    = acc_i[j_i] ? (acc_i ^ poly_ext) : acc_i;

endmodule

// File: rtl/gf_serial_mulred.sv
// Serial shift-and-add multiplier (integer or carry-less) with optional
// bit-serial reduction modulo a GF(2^m) polynomial.
// Optional build macro: GF_RADIX4_EN consumes two bits of b per MUL edge.
module gf_serial_mulred
   import gf_pkg::*;
#(
   parameter int DATA_WIDTH = W
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic                          op_enable,
   input  logic                          red_funct,
   input  logic                          carry_option,
   input  logic [$clog2(DATA_WIDTH):0]   in_width,
   input  logic [DATA_WIDTH:0]           polyn_red_in,
   input  logic [DATA_WIDTH-1:0]         in_a,
   input  logic [DATA_WIDTH-1:0]         in_b,
   output logic [2*DATA_WIDTH-1:0]       out_mult,
   output logic [DATA_WIDTH-1:0]         out_poly,
   output logic                          op_finish,
   output logic                          busy
);

   localparam int              MW        = $clog2(DATA_WIDTH) + 1;
   localparam int              STEPS     = DATA_WIDTH / RADIX_BITS;
   localparam logic [MW-1:0]   LAST_STEP = MW'(STEPS - 1);
   localparam logic [MW-1:0]   FULL_M    = MW'(DATA_WIDTH);

   state_e                  state_q,    state_d;
   logic [MW-1:0]           cnt_q,      cnt_d;
   logic [2*DATA_WIDTH-1:0] a_q,        a_d;
   logic [DATA_WIDTH-1:0]   b_q,        b_d;
   logic [2*DATA_WIDTH-1:0] acc_q,      acc_d;
   logic [2*DATA_WIDTH-1:0] prod_q,     prod_d;
   logic [DATA_WIDTH:0]     poly_q,     poly_d;
   logic [MW-1:0]           m_q,        m_d;
   logic                    red_q,      red_d;
   logic                    int_q,      int_d;
   logic [2*DATA_WIDTH-1:0] out_mult_q, out_mult_d;
   logic [DATA_WIDTH-1:0]   out_poly_q, out_poly_d;

   logic [MW-1:0]           m_eff;
   logic [DATA_WIDTH-1:0]   op_mask;
   logic [2*DATA_WIDTH-1:0] pp;
   logic [2*DATA_WIDTH-1:0] mul_acc;
   logic [2*DATA_WIDTH-1:0] red_acc;
`ifdef GF_RADIX4_EN
   logic [2*DATA_WIDTH-1:0] pp_hi;
`endif

   // Effective field degree and operand mask for the request being sampled.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      m_eff   = in_width;
      op_mask = '1;
      if (in_width == '0 || in_width > FULL_M) begin
         m_eff = FULL_M;
      end
      if (red_funct) begin
         for (int k = 0; k < DATA_WIDTH; k++) begin
            op_mask[k] = (k < int'(m_eff));
         end
      end
   end

   // One multiplier step: accumulate the shifted multiplicand for the low bit(s) of b.
   always_comb begin
      pp      = b_q[0] ? a_q : '0;
      mul_acc = int_q ? (acc_q + pp) : (acc_q ^ pp);
`ifdef GF_RADIX4_EN
      pp_hi   = b_q[1] ? (a_q << 1) : '0;
      mul_acc = int_q ? (acc_q + pp + pp_hi) : (acc_q ^ pp ^ pp_hi);
`endif
   end

   gf_red_step #(
      .DATA_WIDTH (DATA_WIDTH),
      .MW         (MW)
   ) u_red_step (
      .acc_i  (acc_q),
      .poly_i (poly_q),
      .j_i    (cnt_q),
      .m_i    (m_q),
      .acc_o  (red_acc)
   );

   // Next-state and datapath update for the IDLE/MUL/RED/DONE sequence.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      a_d        = a_q;
      b_d        = b_q;
      acc_d      = acc_q;
      prod_d     = prod_q;
      poly_d     = poly_q;
      m_d        = m_q;
      red_d      = red_q;
      int_d      = int_q;
      out_mult_d = out_mult_q;
      out_poly_d = out_poly_q;

      unique case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (op_enable) begin
               state_d = MUL;
               cnt_d   = '0;
               a_d     = {{DATA_WIDTH{1'b0}}, in_a & op_mask};
               b_d     = in_b & op_mask;
               acc_d   = '0;
               poly_d  = polyn_red_in;
               m_d     = m_eff;
               red_d   = red_funct;
               int_d   = carry_option & ~red_funct;
            end
         end
         MUL: begin
            acc_d = mul_acc;
            a_d   = a_q << RADIX_BITS;
            b_d   = b_q >> RADIX_BITS;
            cnt_d = cnt_q + MW'(1);
            if (cnt_q == LAST_STEP) begin
               if (red_q && m_q >= MW'(2)) begin
                  state_d = RED;
                  prod_d  = mul_acc;
                  // Highest possible product bit for m-bit operands is 2m-2.
                  cnt_d   = (m_q << 1) - MW'(2);
               end else begin
                  state_d    = DONE;
                  out_mult_d = mul_acc;
                  out_poly_d = mul_acc[DATA_WIDTH-1:0];
               end
            end
         end
         RED: begin
            acc_d = red_acc;
            cnt_d = cnt_q - MW'(1);
            if (cnt_q == m_q) begin
               state_d    = DONE;
               out_mult_d = prod_q;
               out_poly_d = red_acc[DATA_WIDTH-1:0];
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         a_q        <= '0;
         b_q        <= '0;
         acc_q      <= '0;
         prod_q     <= '0;
         poly_q     <= '0;
         m_q        <= '0;
         red_q      <= 1'b0;
         int_q      <= 1'b0;
         out_mult_q <= '0;
         out_poly_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         a_q        <= a_d;
         b_q        <= b_d;
         acc_q      <= acc_d;
         prod_q     <= prod_d;
         poly_q     <= poly_d;
         m_q        <= m_d;
         red_q      <= red_d;
         int_q      <= int_d;
         out_mult_q <= out_mult_d;
         out_poly_q <= out_poly_d;
      end
   end

   assign out_mult  = out_mult_q;
   assign out_poly  = out_poly_q;
   assign op_finish = (state_q == DONE);
   assign busy      = (state_q == MUL) || (state_q == RED);

endmodule

// File: tb/tb_gf_serial_mulred.sv
// Scoreboard bench for gf_serial_mulred (W=32): the stimulus side pushes the
// expected product, reduced value and completion edge; a monitor pops and
// compares whenever op_finish is seen.
module tb_gf_serial_mulred;

   localparam int TW = 32;
`ifdef GF_RADIX4_EN
   localparam int MUL_EDGES = TW / 2;
`else
   localparam int MUL_EDGES = TW;
`endif

   typedef struct {
      logic [63:0] mult;
      logic [31:0] poly;
      int          fin_edge;
   } exp_t;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        op_enable = 1'b0;
   logic        red_funct = 1'b0;
   logic        carry_option = 1'b0;
   logic [5:0]  in_width = '0;
   logic [32:0] polyn_red_in = '0;
   logic [31:0] in_a = '0;
   logic [31:0] in_b = '0;
   logic [63:0] out_mult;
   logic [31:0] out_poly;
   logic        op_finish;
   logic        busy;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   edge_cnt = 0;
   exp_t exp_q[$];

   gf_serial_mulred #(.DATA_WIDTH(TW)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .op_enable    (op_enable),
      .red_funct    (red_funct),
      .carry_option (carry_option),
      .in_width     (in_width),
      .polyn_red_in (polyn_red_in),
      .in_a         (in_a),
      .in_b         (in_b),
      .out_mult     (out_mult),
      .out_poly     (out_poly),
      .op_finish    (op_finish),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, req, edge_cnt);
      end
   endtask

   // Reference model: polynomial product over GF(2).
   function automatic logic [63:0] clmul(input logic [31:0] a, input logic [31:0] b);
      logic [63:0] r = '0;
      for (int i = 0; i < 32; i++) begin
         if (b[i]) r ^= ({32'b0, a} << i);
      end
      return r;
   endfunction

   // Reference model: remainder of p modulo the degree-m polynomial.
   function automatic logic [31:0] reduce(input logic [63:0] p, input logic [32:0] poly, input int m);
      for (int d = 63; d >= m; d--) begin
         if (p[d]) p ^= ({31'b0, poly} << (d - m));
      end
      return p[31:0];
   endfunction

   function automatic int eff_m(input logic [5:0] w);
      return (w == 6'd0 || w > 6'd32) ? 32 : int'(w);
   endfunction

   // Drive one request at the current negedge; the next posedge is its edge 0.
   task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [5:0] w,
                           input logic [32:0] poly, input logic red, input logic carry);
      exp_t        e;
      int          m;
      logic [31:0] mask, am, bm;
      logic [63:0] p;
      m    = eff_m(w);
      mask = (m == 32) ? 32'hFFFF_FFFF : ((32'h1 << m) - 32'h1);
      am   = red ? (a & mask) : a;
      bm   = red ? (b & mask) : b;
      p    = (red || !carry) ? clmul(am, bm) : ({32'b0, am} * {32'b0, bm});
      e.mult     = p;
      e.poly     = red ? reduce(p, poly, m) : p[31:0];
      e.fin_edge = edge_cnt + 1 + ((red && m >= 2) ? (MUL_EDGES + m - 1) : MUL_EDGES);
      in_a         = a;
      in_b         = b;
      in_width     = w;
      polyn_red_in = poly;
      red_funct    = red;
      carry_option = carry;
      op_enable    = 1'b1;
      exp_q.push_back(e);
      @(negedge clk);
      op_enable = 1'b0;
   endtask

   // Bounded wait for all outstanding results, then a short quiet window.
   task automatic wait_done();
      for (int k = 0; k < 300 && exp_q.size() != 0; k++) @(negedge clk);
      check("op_timeout_pending", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      repeat (3) @(negedge clk);
   endtask

   // Monitor: every op_finish must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (resetn && op_finish) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_finish: op_finish high with nothing outstanding (edge %0d)", edge_cnt);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("out_mult", out_mult, e.mult);
            check("out_poly", 64'(out_poly), 64'(e.poly));
            check("finish_edge", 64'(edge_cnt), 64'(e.fin_edge));
            check("busy_at_finish", 64'(busy), 64'd0);
         end
      end
   end

   initial begin
      #1;
      check("rst_out_mult", out_mult, 64'd0);
      check("rst_out_poly", 64'(out_poly), 64'd0);
      check("rst_op_finish", 64'(op_finish), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);

      // AES field multiply.
      start_op(32'h57, 32'h83, 6'd8, 33'h11B, 1'b1, 1'b0);
      wait_done();
      // Integer all-ones square.
      start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd0, 33'h0, 1'b0, 1'b1);
      wait_done();
      // Carry-less top-bit square.
      start_op(32'h8000_0000, 32'h8000_0000, 6'd0, 33'h0, 1'b0, 1'b0);
      wait_done();
      // Full-width field, plus the m=0 and m>W aliases of m=32.
      start_op(32'h8000_0000, 32'h2, 6'd32, 33'h1_0000_008D, 1'b1, 1'b0);
      wait_done();
      start_op(32'h8000_0000, 32'h2, 6'd0, 33'h1_0000_008D, 1'b1, 1'b0);
      wait_done();
      start_op(32'hDEAD_BEEF, 32'h1234_5677, 6'd45, 33'h1_0000_008D, 1'b1, 1'b1);
      wait_done();
      // Degenerate m=1 field.
      start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd1, 33'h3, 1'b1, 1'b0);
      wait_done();

      // Start ignored while busy; inputs wiggled afterwards are not used.
      start_op(32'h57, 32'h83, 6'd8, 33'h11B, 1'b1, 1'b0);
      repeat (4) @(negedge clk);
      in_a = 32'h1111_2222; in_b = 32'h3333_4444; in_width = 6'd16;
      red_funct = 1'b0; carry_option = 1'b1; op_enable = 1'b1;
      @(negedge clk);
      op_enable = 1'b0;
      check("busy_during_op", 64'(busy), 64'd1);
      in_a = $urandom; in_b = $urandom;
      wait_done();

      // Back-to-back: request presented during the op_finish cycle.
      start_op(32'hCAFE_F00D, 32'h0BAD_BEEF, 6'd0, 33'h0, 1'b0, 1'b1);
      for (int k = 0; k < 300 && !op_finish; k++) @(negedge clk);
      check("b2b_first_finish_seen", 64'(op_finish), 64'd1);
      start_op(32'h0000_00A5, 32'h0000_003C, 6'd8, 33'h11B, 1'b1, 1'b0);
      check("b2b_busy_next_cycle", 64'(busy), 64'd1);
      wait_done();

      // Reset in the middle of an operation.
      start_op(32'h1234_5678, 32'h9ABC_DEF0, 6'd0, 33'h0, 1'b0, 1'b1);
      repeat (10) @(posedge clk);
      #1 resetn = 1'b0;
      #1;
      check("midrst_out_mult", out_mult, 64'd0);
      check("midrst_out_poly", 64'(out_poly), 64'd0);
      check("midrst_op_finish", 64'(op_finish), 64'd0);
      check("midrst_busy", 64'(busy), 64'd0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      repeat (40) @(negedge clk);
      start_op(32'h57, 32'h83, 6'd8, 33'h11B, 1'b1, 1'b0);
      wait_done();

      // Randomized operations across all modes and degrees.
      for (int n = 0; n < 40; n++) begin
         logic        red, carry;
         logic [5:0]  w;
         logic [32:0] poly;
         int          m;
         red   = 1'($urandom_range(0, 1));
         carry = 1'($urandom_range(0, 1));
         w     = 6'($urandom_range(0, 40));
         m     = eff_m(w);
         poly  = (33'h1 << m) | (33'($urandom) & ((33'h1 << m) - 33'h1)) | 33'h1;
         start_op($urandom, $urandom, w, poly, red, carry);
         wait_done();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached at edge %0d", edge_cnt);
      $fatal(1, "watchdog");
   end

endmodule
